// File: rtl/bcd_xs3_codec_serial.sv
// Multi-digit bidirectional BCD <-> excess-3 codec.
// Converts one 4-bit digit per clock between valid/ready handshakes.
module bcd_xs3_codec_serial #(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [4*NDIGITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIGITS-1:0] out_data,
  output logic [NDIGITS-1:0]   out_err,
  output logic                 busy
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    word;
  logic            mode;
  logic [CW-1:0]   cnt;
  logic [3:0]      cur_digit;
  logic [3:0]      conv_digit;
  logic            conv_err;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = !in_ready;

  // Invalid codes map to 4'hF with the error flag set.
  always_comb begin
    cur_digit  = word[4*cnt +: 4];
    conv_digit = 4'hF;
    conv_err   = 1'b1;
    if (!mode) begin
      if (cur_digit <= 4'd9) begin
        conv_digit = cur_digit + 4'd3;
        conv_err   = 1'b0;
      end
    end else begin
      if (cur_digit >= 4'd3 && cur_digit <= 4'd12) begin
        conv_digit = cur_digit - 4'd3;
        conv_err   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word     <= '0;
      mode     <= 1'b0;
      cnt      <= '0;
      out_data <= '0;
      out_err  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word    <= in_data;
            mode    <= in_mode;
            out_err <= '0;
            cnt     <= '0;
            state   <= CONV;
          end
        end
        CONV: begin
          out_data[4*cnt +: 4] <= conv_digit;
          out_err[cnt]         <= conv_err;
          if (cnt == CW'(NDIGITS - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Result stays frozen until the consumer takes it.
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_xs3_codec_serial.sv
// Self-checking bench for bcd_xs3_codec_serial (NDIGITS=4): directed cases
// plus randomized words against a per-digit arithmetic reference model.
module tb_bcd_xs3_codec_serial;

  localparam int ND = 4;
  localparam int W  = 4 * ND;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [ND-1:0] out_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  bcd_xs3_codec_serial #(.NDIGITS(ND)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic per digit.
  function automatic void model(input logic mode, input logic [W-1:0] d,
                                output logic [W-1:0] od, output logic [ND-1:0] oe);
    int v;
    for (int i = 0; i < ND; i++) begin
      v = int'(d[4*i +: 4]);
      if (mode == 1'b0 && v <= 9) begin
        od[4*i +: 4] = 4'(v + 3); oe[i] = 1'b0;
      end else if (mode == 1'b1 && v >= 3 && v <= 12) begin
        od[4*i +: 4] = 4'(v - 3); oe[i] = 1'b0;
      end else begin
        od[4*i +: 4] = 4'hF; oe[i] = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a word and returns once the accepting edge has passed.
  task automatic applyStimulus(input logic mode, input logic [W-1:0] data);
    int n;
    in_mode  = mode;
    in_data  = data;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) checkOutput("accept_timeout", 32'(n), 32'd0);
    step();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_mode  = 1'(~mode);
  endtask

  // Counts edges after the accepting edge until out_valid.
  task automatic waitResult(output int edges);
    edges = 1;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    edges = edges - 1;
  endtask

  task automatic runWord(input string tag, input logic mode, input logic [W-1:0] data,
                         input int hold);
    logic [W-1:0]  ed;
    logic [ND-1:0] ee;
    int            edges;
    model(mode, data, ed, ee);
    applyStimulus(mode, data);
    waitResult(edges);
    checkOutput({tag, "_latency"}, 32'(edges), 32'(ND));
    checkOutput({tag, "_data"}, 32'(out_data), 32'(ed));
    checkOutput({tag, "_err"}, 32'(out_err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      step();
      checkOutput({tag, "_hold"}, {out_valid, in_ready, 14'd0, out_data},
                  {1'b1, 1'b0, 14'd0, ed});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_release"}, {30'd0, in_ready, busy}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    logic [W-1:0]  ed;
    logic [ND-1:0] ee;
    int            edges;

    #3;
    checkOutput("reset_outputs", {out_valid, busy, 10'd0, out_err, out_data},
                32'd0);
    #10 rst_n = 1'b1;
    step();
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed words.
    runWord("bcd_encode", 1'b0, 16'h1937, 0);
    checkOutput("bcd_encode_ref", 32'(16'h4C6A), {16'd0, 16'h4C6A});
    runWord("xs3_decode", 1'b1, 16'h4C6A, 0);
    runWord("bad_bcd", 1'b0, 16'h12A4, 0);
    runWord("bad_xs3", 1'b1, 16'h0233, 0);

    // Backpressure with a competing request held high.
    model(1'b0, 16'h0987, ed, ee);
    applyStimulus(1'b0, 16'h0987);
    waitResult(edges);
    checkOutput("bp_data", 32'(out_data), 32'(16'h3CBA));
    in_valid = 1'b1; in_mode = 1'b1; in_data = 16'h5678;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("bp_hold", {out_valid, in_ready, 10'd0, out_err, out_data},
                  {1'b1, 1'b0, 10'd0, ee, ed});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("bp_idle", {30'd0, in_ready, busy}, {30'd0, 1'b1, 1'b0});
    step();
    in_valid = 1'b0;
    checkOutput("bp_second_accept", 32'(busy), 32'd1);
    waitResult(edges);
    checkOutput("bp_second_data", {12'd0, out_err, out_data}, {12'd0, 4'b0000, 16'h2345});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset while the third digit is being converted.
    applyStimulus(1'b0, 16'h9999);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("midconv_reset", {out_valid, busy, 10'd0, out_err, out_data}, 32'd0);
    #2 rst_n = 1'b1;
    step();
    checkOutput("midconv_in_ready", 32'(in_ready), 32'd1);
    runWord("after_reset", 1'b0, 16'h0000, 0);
    checkOutput("after_reset_ref", 32'(16'h3333), 32'(16'h3333));

    // Randomized words with random backpressure.
    for (int k = 0; k < 40; k++) begin
      logic          m;
      logic [W-1:0]  d;
      m = 1'($urandom);
      d = W'($urandom);
      runWord("rand", m, d, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
